// File: rtl/traffic_pkg.sv
// Shared lane-state type, road geometry and road-mask helpers
// for the signal head driver.
package traffic_pkg;

  typedef enum logic [1:0] {
    L_RED,
    L_GREEN,
    L_AMBER
  } lane_state_t;

  localparam int N_ROADS        = 4;
  localparam int LANES_PER_ROAD = 3;
  localparam int N_LANES        = N_ROADS * LANES_PER_ROAD;
  localparam int FLASH_CYC      = 8;

  function automatic int road_of(input int lane);
    return lane / LANES_PER_ROAD;
  endfunction

  function automatic logic [N_LANES-1:0] road_mask(input int road);
    logic [N_LANES-1:0] m;
    m = '0;
    for (int l = 0; l < N_LANES; l++) begin
      m[l] = (road_of(l) == road);
    end
    return m;
  endfunction

  function automatic logic [N_ROADS-1:0] road_hits(
    input logic [N_LANES-1:0] v
  );
    logic [N_ROADS-1:0] h;
    h = '0;
    for (int r = 0; r < N_ROADS; r++) begin
      h[r] = |(v & road_mask(r));
    end
    return h;
  endfunction

endpackage

// File: rtl/lane_fsm.sv
// One lane's red/green/amber sequencer with minimum green,
// full amber and a kill input that forces red at once.
module lane_fsm
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYC = 3,
  parameter int AMBER_CYC     = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req,
  input  logic        permit,
  input  logic        kill,
  output lane_state_t state,
  output logic        amber_done
);

  localparam int HW = $clog2(MIN_GREEN_CYC + 1);
  localparam int AW = $clog2(AMBER_CYC + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_GREEN_CYC - 1);
  localparam logic [AW-1:0] AMB_INIT  = AW'(AMBER_CYC - 1);

  logic [HW-1:0] hold;
  logic [AW-1:0] amb;

  // Lane sequencing; kill drops straight to red with no amber
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= L_RED;
      hold  <= '0;
      amb   <= '0;
    end else if (kill) begin
      state <= L_RED;
      hold  <= '0;
      amb   <= '0;
    end else begin
      unique case (state)
        L_RED: begin
          if (req && permit) begin
            state <= L_GREEN;
            hold  <= HOLD_INIT;
          end
        end
        L_GREEN: begin
          if (hold != '0) begin
            hold <= hold - HW'(1);
          end else if (!req) begin
            state <= L_AMBER;
            amb   <= AMB_INIT;
          end
        end
        L_AMBER: begin
          if (amb != '0) begin
            amb <= amb - AW'(1);
          end else begin
            state <= L_RED;
          end
        end
        default: state <= L_RED;
      endcase
    end
  end

  // Flags the edge on which this lane leaves amber for red
  always_comb begin
    amber_done = (state == L_AMBER) && (amb == '0) && !kill;
  end

endmodule

// File: rtl/signal_head_driver.sv
// Grant vector to lamp drives with conflict lockout and all-red clearance.
// Optional fault flash of the red lamps: define SIGNAL_FLASH_EN.
module signal_head_driver
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYC = 3,
  parameter int AMBER_CYC     = 4,
  parameter int ALLRED_CYC    = 2
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [N_LANES-1:0] id,
  output logic [N_LANES-1:0] red,
  output logic [N_LANES-1:0] amber,
  output logic [N_LANES-1:0] green,
  output logic               fault,
  output logic               busy
);

  localparam int CW = $clog2(ALLRED_CYC + 2);
  localparam logic [CW-1:0] ALLRED_INIT = CW'(ALLRED_CYC);

  lane_state_t        st [N_LANES];
  logic [N_LANES-1:0] done;
  logic [N_LANES-1:0] permit;
  logic [N_LANES-1:0] req;
  logic [N_LANES-1:0] grn;
  logic [N_LANES-1:0] amb;
  logic [N_LANES-1:0] rd;
  logic [N_LANES-1:0] act;
  logic [CW-1:0]      allred;
  logic               conflict;
  logic               trip;
  logic               kill;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_fsm #(
      .MIN_GREEN_CYC(MIN_GREEN_CYC),
      .AMBER_CYC    (AMBER_CYC)
    ) u_lane (
      .clock     (clock),
      .clear     (clear),
      .req       (req[g]),
      .permit    (permit[g]),
      .kill      (kill),
      .state     (st[g]),
      .amber_done(done[g])
    );
  end

  // Decode lane states into lamp vectors
  always_comb begin
    grn = '0;
    amb = '0;
    rd  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      grn[i] = (st[i] == L_GREEN);
      amb[i] = (st[i] == L_AMBER);
      rd[i]  = (st[i] == L_RED);
    end
    act = grn | amb;
  end

  // Conflict detect on requests and on live lamps; fault ignores id
  always_comb begin
    conflict = !$onehot0(road_hits(id)) ||
               !$onehot0(road_hits(act));
    trip     = !fault && conflict;
    kill     = fault || trip;
    req      = fault ? '0 : id;
  end

  // Per-lane permit: no other road lit, clearance done or road already green
  always_comb begin
    permit = '0;
    for (int i = 0; i < N_LANES; i++) begin
      permit[i] = !(|(act & ~road_mask(road_of(i)))) &&
                  ((allred == '0) ||
                   (|(grn & road_mask(road_of(i)))));
    end
  end

  // All-red clearance counter, reloaded on every amber to red
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      allred <= '0;
    end else if (kill) begin
      allred <= '0;
    end else if (|done) begin
      allred <= ALLRED_INIT;
    end else if (allred != '0) begin
      allred <= allred - CW'(1);
    end
  end

  // Sticky fault, cleared only by reset
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      fault <= 1'b0;
    end else if (trip) begin
      fault <= 1'b1;
    end
  end

  assign green = grn;
  assign amber = amb;
  assign busy  = (|amb) || (allred != '0);

`ifdef SIGNAL_FLASH_EN
  localparam int FW = $clog2(FLASH_CYC + 1);

  logic          flash_on;
  logic [FW-1:0] fcnt;

  // Red flash phase while faulted; first phase is on
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      flash_on <= 1'b1;
      fcnt     <= '0;
    end else if (trip) begin
      flash_on <= 1'b1;
      fcnt     <= '0;
    end else if (fault) begin
      if (fcnt == FW'(FLASH_CYC - 1)) begin
        fcnt     <= '0;
        flash_on <= ~flash_on;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign red = (fault && !flash_on) ? '0 : rd;
`else
  assign red = rd;
`endif

endmodule
